// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_KILL = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface if_fetch_unit_if;
  import mips_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer with push/pop/flush and registered head outputs,
// so decode never sees a combinational path from the memory read data.
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic                   head_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, wr_q, rd_n, wr_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             do_push, do_pop;
  fetch_entry_t     head_n;

  // Pointer/count update and the entry that will sit at the head next cycle.
  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q < CNT_W'(DEPTH)) || do_pop);
    rd_n    = rd_q;
    wr_n    = wr_q;
    cnt_n   = cnt_q;
    head_n  = head;
    if (flush) begin
      rd_n  = '0;
      wr_n  = '0;
      cnt_n = '0;
    end else begin
      if (do_pop)  rd_n = rd_q + PTR_W'(1);
      if (do_push) wr_n = wr_q + PTR_W'(1);
      cnt_n = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      // A word written into the slot that becomes the head bypasses the array.
      if (do_push && (wr_q == rd_n)) head_n = wdata;
      else                           head_n = mem_q[rd_n];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      head       <= '0;
      head_valid <= 1'b0;
    end else begin
      rd_q       <= rd_n;
      wr_q       <= wr_n;
      cnt_q      <= cnt_n;
      head       <= head_n;
      head_valid <= (cnt_n != '0);
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in
// flight, buffers returned words and flushes wrong-path fetches on redirect.
module if_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_fetch_unit_if.master       imem,
  output logic [XLEN-1:0]       ins,
  output logic [XLEN-1:0]       pc,
  output logic                  ins_valid,
  input  logic                  id_ready,
  input  logic                  redirect,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  br_taken,
  input  logic [XLEN-1:0]       br_target
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_t    state_q, state_n;
  logic [XLEN-1:0] fpc_q, req_pc_q, target;
  logic            flush, pop, rsp, live_push, grant, req_c;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occ;
  fetch_entry_t    head, wentry;

  // The branch belongs to the older instruction, so it beats the decode redirect.
  assign flush  = br_taken | redirect;
  assign target = word_align(br_taken ? br_target : redirect_pc);
  assign pop    = ins_valid & id_ready;
  assign wentry = '{ins: imem.imem_rdata, pc: req_pc_q};

  // Next-state and request decision; a new request is only issued when the
  // buffer can absorb it together with anything still in flight.
  always_comb begin
    state_n   = state_q;
    rsp       = 1'b0;
    live_push = 1'b0;
    occ       = '0;
    req_c     = 1'b0;
    grant     = 1'b0;

    rsp       = imem.imem_rvalid && (state_q != IDLE);
    live_push = rsp && (state_q == WAIT) && !flush;
    occ       = OCC_W'(count) - OCC_W'(pop) + OCC_W'(live_push);
    req_c     = rst_n && !flush && ((state_q == IDLE) || rsp) &&
                (occ < OCC_W'(FIFO_DEPTH));
    grant     = req_c && imem.imem_gnt;

    if (flush) begin
      state_n = ((state_q != IDLE) && !imem.imem_rvalid) ? WAIT_KILL : IDLE;
    end else if (grant) begin
      state_n = WAIT;
    end else if (rsp) begin
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fpc_q    <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_n;
      if (flush) begin
        fpc_q <= target;
      end else if (grant) begin
        fpc_q    <= fpc_q + XLEN'(4);
        req_pc_q <= fpc_q;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (live_push),
    .pop        (pop),
    .flush      (flush),
    .wdata      (wentry),
    .head       (head),
    .head_valid (ins_valid),
    .count      (count)
  );

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = fpc_q;
  assign ins            = head.ins;
  assign pc             = head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model plus in-order scoreboard.
module tb_if_fetch_unit;
  import mips_fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] ins, pc;
  logic        ins_valid;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        br_taken;
  logic [31:0] br_target;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .ins         (ins),
    .pc          (pc),
    .ins_valid   (ins_valid),
    .id_ready    (id_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .br_taken    (br_taken),
    .br_target   (br_target)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Memory model state
  int          cyc_no = 0;
  int          mem_lat = 1;
  bit          mem_manual = 0;
  bit          gnt_rand = 0;
  bit          pend_valid = 0;
  bit          pend_kill = 0;
  int          pend_due = 0;
  logic [31:0] pend_addr = '0;
  int          pops_seen = 0;

  // Reference model state
  fetch_entry_t sb[$];
  logic [31:0]  exp_pc = 32'h0000_3000;
  fetch_entry_t mon_e;
  logic         mon_fl;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory drives its outputs shortly after each rising edge.
  always @(posedge clk) begin
    cyc_no = cyc_no + 1;
    #1;
    if (!mem_manual) begin
      bus.imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (pend_valid && pend_due == cyc_no) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_addr);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
      end
    end
  end

  // Monitor: scoreboard pops, response capture, flush and grant tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_pc     = 32'h0000_3000;
      pend_valid = 0;
      pend_kill  = 0;
    end else begin
      mon_fl = redirect | br_taken;
      if (ins_valid && id_ready && !mon_fl) begin
        pops_seen++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL pop_empty: got pc=%h ins=%h, required no valid entry", pc, ins);
        end else begin
          mon_e = sb.pop_front();
          if (ins !== mon_e.ins || pc !== mon_e.pc || pc !== exp_pc) begin
            miscompares++;
            $display("FAIL pop_order: got pc=%h ins=%h, required pc=%h ins=%h",
                     pc, ins, exp_pc, mon_e.ins);
          end
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (pend_valid && pend_due == cyc_no) begin
        if (!pend_kill && !mon_fl) sb.push_back('{ins: mem_word(pend_addr), pc: pend_addr});
        pend_valid = 0;
      end
      if (mon_fl) begin
        sb.delete();
        exp_pc = (br_taken ? br_target : redirect_pc) & 32'hFFFF_FFFC;
        if (pend_valid) pend_kill = 1;
      end
      if (bus.imem_req && bus.imem_gnt) begin
        vectors++;
        if (pend_valid) begin
          miscompares++;
          $display("FAIL outstanding: got 2 requests in flight, required at most 1");
        end
        pend_valid = 1;
        pend_kill  = 0;
        pend_addr  = bus.imem_addr;
        pend_due   = cyc_no + mem_lat;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst_n    = 1'b0;
    redirect = 1'b0;
    br_taken = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL rst_req: got %b required 0", bus.imem_req);
    end
    vectors++;
    if (ins_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_valid: got %b required 0", ins_valid);
    end
    vectors++;
    if (ins !== 32'h0 || pc !== 32'h0) begin
      miscompares++; $display("FAIL rst_head: got ins=%h pc=%h required 0/0", ins, pc);
    end
    vectors++;
    if (bus.imem_addr !== 32'h0000_3000) begin
      miscompares++; $display("FAIL rst_addr: got %h required 00003000", bus.imem_addr);
    end
  endtask

  task automatic test_stream();
    mem_lat  = 1;
    id_ready = 1'b1;
    apply_reset();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      vectors++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000 + 32'(4 * c)) begin
        miscompares++;
        $display("FAIL stream_req c%0d: got req=%b addr=%h required 1/%h",
                 c, bus.imem_req, bus.imem_addr, 32'h3000 + 32'(4 * c));
      end
      vectors++;
      if (ins_valid !== (c >= 2)) begin
        miscompares++;
        $display("FAIL stream_valid c%0d: got %b required %b", c, ins_valid, (c >= 2));
      end
      if (c >= 2) begin
        vectors++;
        if (pc !== 32'h3000 + 32'(4 * (c - 2))) begin
          miscompares++;
          $display("FAIL stream_pc c%0d: got %h required %h", c, pc, 32'h3000 + 32'(4 * (c - 2)));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    apply_reset();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (c >= 2) begin
        vectors++;
        if (bus.imem_req !== 1'b0) begin
          miscompares++; $display("FAIL bp_req c%0d: got %b required 0", c, bus.imem_req);
        end
        vectors++;
        if (ins_valid !== 1'b1 || pc !== 32'h3000 || ins !== mem_word(32'h3000)) begin
          miscompares++;
          $display("FAIL bp_hold c%0d: got v=%b pc=%h ins=%h required 1/00003000/%h",
                   c, ins_valid, pc, ins, mem_word(32'h3000));
        end
      end
    end
    tick();
    id_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3008) begin
      miscompares++;
      $display("FAIL bp_resume: got req=%b addr=%h required 1/00003008", bus.imem_req, bus.imem_addr);
    end
    repeat (8) tick();
  endtask

  task automatic test_redirect();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0010;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL redir_req: got %b required 0", bus.imem_req);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0040_0010 || ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_t1: got req=%b addr=%h v=%b required 1/00400010/0",
               bus.imem_req, bus.imem_addr, ins_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_t2: got v=%b required 0", ins_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b1 || pc !== 32'h0040_0010 || ins !== mem_word(32'h0040_0010)) begin
      miscompares++;
      $display("FAIL redir_t3: got v=%b pc=%h required 1/00400010", ins_valid, pc);
    end
    repeat (4) tick();
  endtask

  task automatic test_priority();
    tick();
    br_taken    = 1'b1;
    br_target   = 32'h0000_3100;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3200;
    tick();
    br_taken = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3100) begin
      miscompares++;
      $display("FAIL prio_addr: got req=%b addr=%h required 1/00003100", bus.imem_req, bus.imem_addr);
    end
    repeat (2) tick();
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b1 || pc !== 32'h0000_3100) begin
      miscompares++; $display("FAIL prio_pc: got v=%b pc=%h required 1/00003100", ins_valid, pc);
    end
    repeat (3) tick();
  endtask

  task automatic test_align_wrap();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2003;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_addr !== 32'h0000_2000) begin
      miscompares++; $display("FAIL align: got %h required 00002000", bus.imem_addr);
    end
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL wrap_top: got req=%b addr=%h required 1/fffffffc", bus.imem_req, bus.imem_addr);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_0000) begin
      miscompares++;
      $display("FAIL wrap_zero: got req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
    end
    repeat (6) tick();
  endtask

  task automatic test_wait_kill();
    id_ready = 1'b1;
    apply_reset();
    mem_lat = 3;
    tick();
    rst_n = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_5000;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL kill_flush_req: got %b required 0", bus.imem_req);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL kill_wait_req: got %b required 0", bus.imem_req);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_5000 || ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL kill_resume: got req=%b addr=%h v=%b required 1/00005000/0",
               bus.imem_req, bus.imem_addr, ins_valid);
    end
    repeat (14) tick();
    mem_lat = 1;
  endtask

  task automatic test_back_to_back();
    apply_reset();
    mem_lat  = 2;
    gnt_rand = 1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      id_ready    = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      br_taken    = ($urandom_range(0, 31) == 0);
      br_target   = $urandom;
      if (i == 200) mem_lat = 1;
    end
    tick();
    redirect = 1'b0;
    br_taken = 1'b0;
    id_ready = 1'b1;
    gnt_rand = 0;
    repeat (10) tick();
    @(negedge clk);
    vectors++;
    if (pops_seen < 50) begin
      miscompares++; $display("FAIL b2b_progress: got %0d pops required at least 50", pops_seen);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mem_manual      = 1;
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    mem_lat  = 1;
    id_ready = 1'b1;
    apply_reset();
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL rm_wait: got req=%b required 0", bus.imem_req);
    end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0 || ins_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_inreset: got req=%b v=%b required 0/0", bus.imem_req, ins_valid);
    end
    tick();
    tick();
    rst_n           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0000_3000) begin
      miscompares++;
      $display("FAIL rm_restart: got req=%b addr=%h required 1/00003000", bus.imem_req, bus.imem_addr);
    end
    mem_manual = 0;
    tick();
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b0) begin
      miscompares++; $display("FAIL rm_stray: got v=%b required 0", ins_valid);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (ins_valid !== 1'b1 || pc !== 32'h0000_3000 || ins !== mem_word(32'h0000_3000)) begin
      miscompares++;
      $display("FAIL rm_first: got v=%b pc=%h ins=%h required 1/00003000/%h",
               ins_valid, pc, ins, mem_word(32'h0000_3000));
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      vectors++;
      if (ins_valid && ins === 32'hDEAD_BEEF) begin
        miscompares++; $display("FAIL rm_leak: got ins=deadbeef required any fetched word");
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    id_ready        = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    br_taken        = 1'b0;
    br_target       = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_priority();
    test_align_wrap();
    test_wait_kill();
    test_back_to_back();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
